sb_tx_serializer: RTL and testbench
===================================

Name: sb_tx_serializer

Overview:
- Sideband transmit serializer. It sits directly upstream of the sideband receiver and drives its dataPin/clkPin pair.
- It buffers 64-bit sideband words (encoded messages or data payloads) from the LTSM/TX logic in a small FIFO.
- Each word is shifted out LSB-first with a forwarded, gated clock, followed by a mandatory idle gap.
- The receiver samples data on the falling edge of the forwarded clock.

Parameters:
FIFO_DEPTH, 4, number of 64-bit words buffered; power of 2, >1
GAP_UI, 32, idle unit intervals (forwarded clock held low) after every 64-bit packet; >=1

Ports:
clk_800MHz  input  1  single clock for the block
reset_n  input  1  asynchronous, active-low reset
enable_i  input  1  allows a new packet to start; does not abort a packet in progress
data_i  input  64  word to transmit
valid_i  input  1  data_i valid
ready_o  output  1  FIFO can accept a word; equals (fifo_count_o != FIFO_DEPTH)
dataPin_o  output  1  serial data to the receiver
clkPin_o  output  1  forwarded serial clock to the receiver
busy_o  output  1  high while in SHIFT or GAP
msg_sent_o  output  1  one-cycle pulse when the last bit's low clock phase is driven
fifo_count_o  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (reset_n low, asynchronous):
  - Forces dataPin_o=0, clkPin_o=0, busy_o=0, msg_sent_o=0, fifo_count_o=0, ready_o=1.
  - Sets state IDLE and clears the FIFO pointers, shift register and counters.
  - A reset during SHIFT or GAP abandons the packet immediately; the FIFO contents are lost.
- FIFO:
  - Push occurs when valid_i && ready_o at a clock edge; valid_i while full is ignored with no overwrite.
  - Pop occurs only on the IDLE->SHIFT transition.
  - Simultaneous push and pop is legal; the count is unchanged in that case.
  - Pointers wrap modulo FIFO_DEPTH.
- All pin outputs are registered.
- Bit timing: 1 UI = 2 clk cycles.
  - High phase: clkPin_o=1 and dataPin_o=current bit.
  - Low phase: clkPin_o=0 and dataPin_o holds the bit.
  - The receiver's falling-edge sample is therefore mid-bit with 1 cycle of setup.
- State machine (IDLE, SHIFT, GAP):
  - IDLE: clkPin_o=0, dataPin_o=0.
    - If enable_i && fifo_count_o!=0 at cycle T: pop the head word into the shift register, clear bit_cnt and phase, go to SHIFT.
  - SHIFT, per bit k (0..63):
    - Cycle T+1+2k: clkPin_o=1, dataPin_o=word[k].
    - Cycle T+2+2k: clkPin_o=0, dataPin_o=word[k].
    - bit_cnt is 6 bits and increments after each low phase.
    - At k=63 low phase (cycle T+128), msg_sent_o=1 for that cycle; next state is GAP.
  - GAP:
    - Runs for 2*GAP_UI cycles (T+129 .. T+128+2*GAP_UI) with clkPin_o=0 and dataPin_o=0.
    - The gap counter is wide enough for 2*GAP_UI.
    - Then go to IDLE.
  - Back-to-back packets: with default GAP_UI, the next pop occurs at T+193 and the next high phase at T+194, so the packet period is 193 cycles.
- enable_i:
  - Sampled only in IDLE.
  - Deassertion during SHIFT/GAP lets the current packet and its gap complete, then the block holds in IDLE.
  - Pushes are still accepted while enable_i is low.
- No truncated packet is ever driven except on reset.
- clkPin_o never toggles outside SHIFT.
- busy_o is 1 throughout SHIFT and GAP, including the first SHIFT cycle (T+1).

Test Plan:
- Single word 64'hA5A5_0000_FFFF_1234, enable_i=1 -> exactly 64 clkPin_o pulses, dataPin_o LSB-first (bits 0,0,1,0,1,1,0,0...), msg_sent_o at T+128, busy_o low after GAP. Loopback into the sideband receiver returns the identical 64-bit word.
- Two words pushed back-to-back (64'h1, 64'h8000_0000_0000_0000) -> second packet's first clkPin_o rise exactly 193 cycles after the first's; clkPin_o=0 and dataPin_o=0 for all 64 gap cycles.
- Push 5 words with enable_i=0 -> ready_o drops after the 4th, the 5th is ignored, fifo_count_o=4. Raise enable_i -> the 4 words go out in push order, fifo_count_o decrements at each pop, ready_o=1 after the first pop.
- Deassert enable_i at bit 20 of a packet with 2 words queued -> current packet and gap complete, then no further clkPin_o activity, fifo_count_o=1; re-enable -> the remaining word is sent.
- Assert reset_n=0 at bit 40 -> dataPin_o, clkPin_o, busy_o and fifo_count_o go to 0 immediately with no further clock edges; after release, a new push transmits cleanly from bit 0.
- GAP_UI=4 build -> gap is exactly 8 cycles, and the back-to-back packet period is 137 cycles.

Source files
------------

// File: rtl/sb_tx_serializer.sv
// Sideband transmit serializer: buffers 64-bit words in a small FIFO and shifts each
// one out LSB-first with a forwarded, gated clock followed by a fixed idle gap.
module sb_tx_serializer #(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_UI     = 32
) (
  input  logic                          clk_800MHz,
  input  logic                          reset_n,
  input  logic                          enable_i,
  input  logic [63:0]                   data_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  output logic                          dataPin_o,
  output logic                          clkPin_o,
  output logic                          busy_o,
  output logic                          msg_sent_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = $clog2(2 * GAP_UI + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [63:0]   shift_q, shift_d;
  logic [5:0]    bit_cnt_q, bit_cnt_d;
  logic          phase_q, phase_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          data_q, data_d;
  logic          clk_q, clk_d;
  logic          sent_q, sent_d;

  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [63:0]   mem_q [FIFO_DEPTH];
  logic          push, pop;

  assign ready_o = (count_q != CW'(FIFO_DEPTH));
  assign push    = valid_i && ready_o;
  assign pop     = (state_q == S_IDLE) && enable_i && (count_q != '0);

  always_ff @(posedge clk_800MHz) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_800MHz or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // Pin values are computed one cycle ahead so every pin comes straight from a flop;
  // phase_q=0 is the high clock phase of the current bit, phase_q=1 the low phase.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    phase_d   = phase_q;
    gap_d     = gap_q;
    data_d    = data_q;
    clk_d     = clk_q;
    sent_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        data_d = 1'b0;
        clk_d  = 1'b0;
        if (pop) begin
          shift_d   = mem_q[rd_ptr_q];
          bit_cnt_d = '0;
          phase_d   = 1'b0;
          clk_d     = 1'b1;
          data_d    = mem_q[rd_ptr_q][0];
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (!phase_q) begin
          clk_d   = 1'b0;
          phase_d = 1'b1;
          sent_d  = (bit_cnt_q == 6'd63);
        end else if (bit_cnt_q == 6'd63) begin
          clk_d   = 1'b0;
          data_d  = 1'b0;
          gap_d   = '0;
          state_d = S_GAP;
        end else begin
          bit_cnt_d = bit_cnt_q + 6'd1;
          phase_d   = 1'b0;
          clk_d     = 1'b1;
          data_d    = shift_q[bit_cnt_d];
        end
      end
      S_GAP: begin
        clk_d  = 1'b0;
        data_d = 1'b0;
        if (gap_q == GW'(2 * GAP_UI - 1)) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_800MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      phase_q   <= 1'b0;
      gap_q     <= '0;
      data_q    <= 1'b0;
      clk_q     <= 1'b0;
      sent_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      phase_q   <= phase_d;
      gap_q     <= gap_d;
      data_q    <= data_d;
      clk_q     <= clk_d;
      sent_q    <= sent_d;
    end
  end

  assign dataPin_o    = data_q;
  assign clkPin_o     = clk_q;
  assign msg_sent_o   = sent_q;
  assign busy_o       = (state_q != S_IDLE);
  assign fifo_count_o = count_q;

endmodule

// File: tb/tb_sb_tx_serializer.sv
// Scoreboard bench for sb_tx_serializer: a falling-edge receiver model reassembles
// each packet and compares it with the word queued when it was pushed.
`timescale 1ns/1ps
module tb_sb_tx_serializer;

  localparam int DEPTH = 4;
  localparam int GAP   = 32;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [63:0] data;
  logic        valid;
  logic        ready, dataPin, clkPin, busy, msgSent;
  logic [2:0]  fifoCount;

  logic        enable4, valid4;
  logic [63:0] data4;
  logic        ready4, dataPin4, clkPin4, busy4, msgSent4;
  logic [2:0]  fifoCount4;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          pktDone = 0;
  int          mdlCount = 0;
  int          riseQ[$];
  logic [63:0] sbQ[$];
  int          rise4Q[$];
  int          gap4Q[$];
  int          base;
  logic        quiet;

  sb_tx_serializer #(.FIFO_DEPTH(DEPTH), .GAP_UI(GAP)) dut (
    .clk_800MHz(clk), .reset_n(reset_n), .enable_i(enable), .data_i(data),
    .valid_i(valid), .ready_o(ready), .dataPin_o(dataPin), .clkPin_o(clkPin),
    .busy_o(busy), .msg_sent_o(msgSent), .fifo_count_o(fifoCount));

  sb_tx_serializer #(.FIFO_DEPTH(DEPTH), .GAP_UI(4)) dut4 (
    .clk_800MHz(clk), .reset_n(reset_n), .enable_i(enable4), .data_i(data4),
    .valid_i(valid4), .ready_o(ready4), .dataPin_o(dataPin4), .clkPin_o(clkPin4),
    .busy_o(busy4), .msg_sent_o(msgSent4), .fifo_count_o(fifoCount4));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [63:0] w);
    @(negedge clk);
    valid = 1'b1;
    data  = w;
    @(posedge clk);
    #1;
    valid = 1'b0;
    if (mdlCount < DEPTH) begin
      sbQ.push_back(w);
      mdlCount++;
    end
  endtask

  task automatic applyStimulusGap4(input logic [63:0] w);
    @(negedge clk);
    valid4 = 1'b1;
    data4  = w;
    @(posedge clk);
    #1;
    valid4 = 1'b0;
  endtask

  task automatic waitPackets(input int n, input int budget);
    int k = 0;
    while (pktDone < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    checkOutput("pktWait", 64'(pktDone), 64'(n));
  endtask

  task automatic waitRise(input int n, input int budget);
    int k = 0;
    while (riseQ.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    checkOutput("riseWait", 64'(riseQ.size()), 64'(n));
  endtask

  // Receiver model: captures dataPin on each falling edge of the forwarded clock.
  initial begin : monitor
    logic        prevClk, hiData, holdErr, gapErr;
    logic [63:0] word, expW;
    int          bitIdx, firstRise;
    prevClk = 1'b0; hiData = 1'b0; holdErr = 1'b0; gapErr = 1'b0;
    word = '0; expW = '0; bitIdx = 0; firstRise = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prevClk = 1'b0;
        bitIdx  = 0;
      end else begin
        if (clkPin && !prevClk) begin
          if (bitIdx == 0) begin
            firstRise = cyc;
            riseQ.push_back(cyc);
            holdErr = 1'b0;
            mdlCount--;
            checkOutput("popCount", 64'(fifoCount), 64'(mdlCount));
            checkOutput("busyFirst", 64'(busy), 64'd1);
          end
          hiData = dataPin;
        end else if (!clkPin && prevClk) begin
          if (dataPin !== hiData) holdErr = 1'b1;
          word[bitIdx] = dataPin;
          if (bitIdx == 63) begin
            checkOutput("msgSent", 64'(msgSent), 64'd1);
            checkOutput("msgCycle", 64'(cyc - firstRise), 64'd127);
            checkOutput("bitHold", 64'(holdErr), 64'd0);
            checkOutput("sbHasWord", 64'(sbQ.size() != 0), 64'd1);
            if (sbQ.size() != 0) begin
              expW = sbQ.pop_front();
              checkOutput("word", word, expW);
            end
            gapErr = 1'b0;
            for (int i = 0; i < 2 * GAP && reset_n; i++) begin
              @(negedge clk);
              if (clkPin !== 1'b0 || dataPin !== 1'b0 || busy !== 1'b1 || msgSent !== 1'b0)
                gapErr = 1'b1;
            end
            if (reset_n) begin
              checkOutput("gapClean", 64'(gapErr), 64'd0);
              @(negedge clk);
              checkOutput("idleAfterGap", 64'(busy), 64'd0);
              pktDone++;
            end
            bitIdx = 0;
          end else begin
            bitIdx++;
          end
        end
        prevClk = clkPin;
      end
    end
  end

  // Timing observer for the short-gap instance.
  initial begin : monitor4
    logic prevClk4, prevBusy4;
    int   riseCnt4, sentCyc4;
    prevClk4 = 1'b0; prevBusy4 = 1'b0; riseCnt4 = 0; sentCyc4 = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prevClk4 = 1'b0; prevBusy4 = 1'b0; riseCnt4 = 0;
      end else begin
        if (clkPin4 && !prevClk4) begin
          if (riseCnt4 % 64 == 0) rise4Q.push_back(cyc);
          riseCnt4++;
        end
        if (msgSent4) sentCyc4 = cyc;
        if (prevBusy4 && !busy4) gap4Q.push_back(cyc - sentCyc4 - 1);
        prevClk4  = clkPin4;
        prevBusy4 = busy4;
      end
    end
  end

  initial begin
    reset_n = 1'b0; enable = 1'b0; valid = 1'b0; data = '0;
    enable4 = 1'b1; valid4 = 1'b0; data4 = '0;
    quiet = 1'b1; base = 0;
    #13;
    checkOutput("rstData", 64'(dataPin), 64'd0);
    checkOutput("rstClk", 64'(clkPin), 64'd0);
    checkOutput("rstBusy", 64'(busy), 64'd0);
    checkOutput("rstSent", 64'(msgSent), 64'd0);
    checkOutput("rstCount", 64'(fifoCount), 64'd0);
    checkOutput("rstReady", 64'(ready), 64'd1);
    @(negedge clk);
    reset_n = 1'b1;

    // Single word
    enable = 1'b1;
    applyStimulus(64'hA5A5_0000_FFFF_1234);
    waitPackets(1, 400);
    checkOutput("t1Busy", 64'(busy), 64'd0);
    checkOutput("t1Count", 64'(fifoCount), 64'd0);

    // Back-to-back pair
    applyStimulus(64'h1);
    applyStimulus(64'h8000_0000_0000_0000);
    waitPackets(3, 600);
    checkOutput("period", 64'(riseQ[riseQ.size()-1] - riseQ[riseQ.size()-2]), 64'd193);

    // Fill with enable low, fifth push dropped
    enable = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(64'hC0DE_0000_0000_0000 | 64'(i * 7 + 3));
    checkOutput("fullReady", 64'(ready), 64'd0);
    checkOutput("fullCount", 64'(fifoCount), 64'd4);
    applyStimulus(64'hDEAD_BEEF_DEAD_BEEF);
    checkOutput("dropCount", 64'(fifoCount), 64'd4);
    @(negedge clk);
    enable = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("popCount3", 64'(fifoCount), 64'd3);
    checkOutput("popReady", 64'(ready), 64'd1);
    waitPackets(7, 1000);

    // Enable dropped mid-packet
    enable = 1'b0;
    applyStimulus(64'h0123_4567_89AB_CDEF);
    applyStimulus(64'hFEDC_BA98_7654_3210);
    base = riseQ.size();
    @(negedge clk);
    enable = 1'b1;
    waitRise(base + 1, 20);
    repeat (40) @(negedge clk);
    enable = 1'b0;
    waitPackets(8, 300);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (clkPin !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    checkOutput("enableHold", 64'(quiet), 64'd1);
    checkOutput("holdCount", 64'(fifoCount), 64'd1);
    checkOutput("holdPkts", 64'(pktDone), 64'd8);
    enable = 1'b1;
    waitPackets(9, 300);

    // Reset in the middle of a packet
    applyStimulus(64'h1111_2222_3333_4444);
    applyStimulus(64'h5555_6666_7777_8888);
    base = riseQ.size();
    waitRise(base + 1, 20);
    repeat (80) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("abortData", 64'(dataPin), 64'd0);
    checkOutput("abortClk", 64'(clkPin), 64'd0);
    checkOutput("abortBusy", 64'(busy), 64'd0);
    checkOutput("abortCount", 64'(fifoCount), 64'd0);
    sbQ.delete();
    mdlCount = 0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(64'h0F0F_F0F0_0F0F_F0F0);
    waitPackets(10, 300);
    checkOutput("sbDrained", 64'(sbQ.size()), 64'd0);

    // Short-gap instance timing
    applyStimulusGap4(64'hAAAA_5555_AAAA_5555);
    applyStimulusGap4(64'h3);
    for (int k = 0; k < 400 && (rise4Q.size() < 2 || gap4Q.size() < 2); k++) @(negedge clk);
    checkOutput("g4Rises", 64'(rise4Q.size()), 64'd2);
    checkOutput("g4Gaps", 64'(gap4Q.size()), 64'd2);
    if (rise4Q.size() >= 2) checkOutput("g4Period", 64'(rise4Q[1] - rise4Q[0]), 64'd137);
    if (gap4Q.size() >= 1) checkOutput("g4GapLen", 64'(gap4Q[0]), 64'd8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
